// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle control unit: widths, ALU op
// encodings, opcode constants, FSM states, trap causes and decode helpers.
package multicycle_ctrl_pkg;

    localparam int WORD_W           = 32;
    localparam int REG_SIZE         = 5;
    localparam int ALU_CONTROL_SIZE = 4;

    localparam logic [ALU_CONTROL_SIZE-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALU_CONTROL_SIZE-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALU_CONTROL_SIZE-1:0] ALU_SLL  = 4'd2;
    localparam logic [ALU_CONTROL_SIZE-1:0] ALU_SLT  = 4'd3;
    localparam logic [ALU_CONTROL_SIZE-1:0] ALU_SLTU = 4'd4;
    localparam logic [ALU_CONTROL_SIZE-1:0] ALU_XOR  = 4'd5;
    localparam logic [ALU_CONTROL_SIZE-1:0] ALU_SRL  = 4'd6;
    localparam logic [ALU_CONTROL_SIZE-1:0] ALU_SRA  = 4'd7;
    localparam logic [ALU_CONTROL_SIZE-1:0] ALU_OR   = 4'd8;
    localparam logic [ALU_CONTROL_SIZE-1:0] ALU_AND  = 4'd9;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        FETCH, DECODE, EXEC, MEM, WB, TRAP
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_ILLEGAL = 2'd1,
        CAUSE_IMEM    = 2'd2,
        CAUSE_DMEM    = 2'd3
    } trap_cause_e;

    typedef enum logic [2:0] {
        CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_ILLEGAL
    } instr_class_e;

    // Only beq/bne are supported branches; every other funct3 is illegal.
    function automatic instr_class_e classify(input logic [6:0] opcode,
                                              input logic [2:0] funct3);
        instr_class_e cls;
        cls = CLS_ILLEGAL;
        case (opcode)
            OPC_R:      cls = CLS_R;
            OPC_I:      cls = CLS_I;
            OPC_LOAD:   cls = CLS_LOAD;
            OPC_STORE:  cls = CLS_STORE;
            OPC_BRANCH: if (funct3 == 3'b000 || funct3 == 3'b001) cls = CLS_BRANCH;
            default:    cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

    // funct7[5] selects SUB only for R-type; for both R and I it picks SRA over SRL.
    function automatic logic [ALU_CONTROL_SIZE-1:0] alu_op(input logic       is_r,
                                                           input logic [2:0] funct3,
                                                           input logic       funct7_5);
        logic [ALU_CONTROL_SIZE-1:0] op;
        case (funct3)
            3'b000:  op = (is_r && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = funct7_5 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_imm_gen.sv
// Immediate generator: sign-extends the I, S or B immediate of the
// instruction register, chosen by opcode. R-type yields zero.
module multicycle_ctrl_imm_gen
    import multicycle_ctrl_pkg::*;
(
    input  logic [11:0]       ir_upper,   // IR[31:20]
    input  logic [11:0]       ir_lower,   // IR[11:0]
    output logic [WORD_W-1:0] imm32
);

    // Format select from the opcode held in the low IR bits.
    always_comb begin
        imm32 = '0;
        case (ir_lower[6:0])
            OPC_I, OPC_LOAD: imm32 = {{20{ir_upper[11]}}, ir_upper};
            OPC_STORE:       imm32 = {{20{ir_upper[11]}}, ir_upper[11:5], ir_lower[11:7]};
            OPC_BRANCH:      imm32 = {{19{ir_upper[11]}}, ir_upper[11], ir_lower[7],
                                      ir_upper[10:5], ir_lower[11:8], 1'b0};
            default:         imm32 = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: FETCH -> DECODE -> EXEC -> (MEM) -> (WB), one
// instruction at a time, with req/ack memory handshakes, wait-limit
// timeouts and a sticky trap state that only reset leaves.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int              WAIT_LIMIT = 16,
    parameter logic [WORD_W-1:0] RESET_IR = 32'h0000_0013
)(
    input  logic                        clk,
    input  logic                        reset,
    input  logic [WORD_W-1:0]           instr,
    output logic                        imemReq,
    input  logic                        imemAck,
    output logic                        dmemReq,
    input  logic                        dmemAck,
    input  logic                        zero,
    output logic [REG_SIZE-1:0]         rs1,
    output logic [REG_SIZE-1:0]         rs2,
    output logic [REG_SIZE-1:0]         rd,
    output logic [WORD_W-1:0]           imm32,
    output logic [ALU_CONTROL_SIZE-1:0] ALUControl,
    output logic                        ALUSrc,
    output logic                        regWrite,
    output logic                        memWrite,
    output logic                        memToReg,
    output logic                        pcWrite,
    output logic                        pcSrc,
    output logic                        trap,
    output logic [1:0]                  trapCause,
    output logic [31:0]                 instret
);

    localparam int                WAIT_W   = $clog2(WAIT_LIMIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(WAIT_LIMIT);

    state_e             state_q, state_d;
    logic [WORD_W-1:0]  ir_q, ir_d;
    logic [WAIT_W-1:0]  wait_q, wait_d, wait_inc;
    trap_cause_e        cause_q, cause_d;
    logic [31:0]        instret_q, instret_d;
    instr_class_e       cls;

    assign cls       = classify(ir_q[6:0], ir_q[14:12]);
    assign wait_inc  = wait_q + 1'b1;
    assign rs1       = ir_q[19:15];
    assign rs2       = ir_q[24:20];
    assign rd        = ir_q[11:7];
    assign trap      = (state_q == TRAP);
    assign trapCause = cause_q;
    assign instret   = instret_q;

    multicycle_ctrl_imm_gen u_imm_gen (
        .ir_upper (ir_q[31:20]),
        .ir_lower (ir_q[11:0]),
        .imm32    (imm32)
    );

    // State, IR, wait counter, trap cause and retire counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            ir_q      <= RESET_IR;
            wait_q    <= '0;
            cause_q   <= CAUSE_NONE;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            wait_q    <= wait_d;
            cause_q   <= cause_d;
            instret_q <= instret_d;
        end
    end

    // Next state and all datapath strobes; operand selects are held from EXEC to retire.
    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        wait_d     = wait_q;
        cause_d    = cause_q;
        imemReq    = 1'b0;
        dmemReq    = 1'b0;
        regWrite   = 1'b0;
        memWrite   = 1'b0;
        memToReg   = 1'b0;
        pcWrite    = 1'b0;
        pcSrc      = 1'b0;
        ALUSrc     = 1'b0;
        ALUControl = ALU_ADD;

        if (state_q == EXEC || state_q == MEM || state_q == WB) begin
            ALUSrc = (cls != CLS_R) && (cls != CLS_BRANCH);
            case (cls)
                CLS_BRANCH:          ALUControl = ALU_SUB;
                CLS_LOAD, CLS_STORE: ALUControl = ALU_ADD;
                default:             ALUControl = alu_op(cls == CLS_R, ir_q[14:12], ir_q[30]);
            endcase
        end

        case (state_q)
            FETCH: begin
                imemReq = 1'b1;
                if (imemAck) begin
                    ir_d    = instr;
                    state_d = DECODE;
                end else if (wait_inc == WAIT_MAX) begin
                    state_d = TRAP;
                    cause_d = CAUSE_IMEM;
                end else begin
                    wait_d = wait_inc;
                end
            end
            DECODE: begin
                if (cls == CLS_ILLEGAL) begin
                    state_d = TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                case (cls)
                    CLS_BRANCH: begin
                        pcSrc   = zero ^ ir_q[12];
                        pcWrite = 1'b1;
                        state_d = FETCH;
                        wait_d  = '0;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        state_d = MEM;
                        wait_d  = '0;
                    end
                    default: state_d = WB;
                endcase
            end
            MEM: begin
                dmemReq  = 1'b1;
                memWrite = (cls == CLS_STORE);
                if (dmemAck) begin
                    if (cls == CLS_STORE) begin
                        pcWrite = 1'b1;
                        state_d = FETCH;
                        wait_d  = '0;
                    end else begin
                        state_d = WB;
                    end
                end else if (wait_inc == WAIT_MAX) begin
                    state_d = TRAP;
                    cause_d = CAUSE_DMEM;
                end else begin
                    wait_d = wait_inc;
                end
            end
            WB: begin
                regWrite = (ir_q[11:7] != '0);
                memToReg = (cls == CLS_LOAD);
                pcWrite  = 1'b1;
                state_d  = FETCH;
                wait_d   = '0;
            end
            TRAP: begin
                state_d = TRAP;
            end
            default: state_d = FETCH;
        endcase

        instret_d = pcWrite ? instret_q + 32'd1 : instret_q;
    end

endmodule
